// File: rtl/lkt_config_pkg.sv
// Default geometry of the lookup table, shared by the writer, the lookup DUT and the environment.
package lkt_config_pkg;
  localparam int RESULT_WIDTH_DEF = 3;
  localparam int NUM_LOOKUPS_DEF  = 8;
  localparam int NUM_CHOICES_DEF  = 2;
endpackage

// File: rtl/lkt_pkg.sv
// Host command encoding and the index/select width derivation for the lookup table.
package lkt_pkg;
  typedef enum logic [1:0] {
    OP_WRITE     = 2'd0,
    OP_CLEAR_ALL = 2'd1,
    OP_READBACK  = 2'd2,
    OP_ILLEGAL   = 2'd3
  } cmd_op_e;

  // A single-row or single-choice table still needs a one-bit index.
  function automatic int calc_idx_w(input int num_lookups);
    return (num_lookups > 1) ? $clog2(num_lookups) : 1;
  endfunction

  function automatic int calc_sel_w(input int num_choices);
    return (num_choices > 1) ? $clog2(num_choices) : 1;
  endfunction
endpackage

// File: rtl/lkt_table_writer_if.sv
// Command/response handshake plus table write/read port of the table writer.
interface lkt_table_writer_if
  import lkt_pkg::*;
#(
  parameter int RESULT_WIDTH = lkt_config_pkg::RESULT_WIDTH_DEF,
  parameter int NUM_LOOKUPS  = lkt_config_pkg::NUM_LOOKUPS_DEF,
  parameter int NUM_CHOICES  = lkt_config_pkg::NUM_CHOICES_DEF
);
  localparam int IDX_W = calc_idx_w(NUM_LOOKUPS);
  localparam int SEL_W = calc_sel_w(NUM_CHOICES);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [1:0]              cmd_op;
  logic [IDX_W-1:0]        cmd_idx;
  logic [SEL_W-1:0]        cmd_sel;
  logic [RESULT_WIDTH-1:0] cmd_data;
  logic                    tbl_we;
  logic [IDX_W-1:0]        tbl_waddr;
  logic [SEL_W-1:0]        tbl_wsel;
  logic [RESULT_WIDTH-1:0] tbl_wdata;
  logic                    tbl_re;
  logic [IDX_W-1:0]        tbl_raddr;
  logic [SEL_W-1:0]        tbl_rsel;
  logic [RESULT_WIDTH-1:0] tbl_rdata;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [RESULT_WIDTH-1:0] rsp_data;
  logic                    rsp_err;
  logic                    busy;

  modport master (
    output cmd_valid, cmd_op, cmd_idx, cmd_sel, cmd_data, tbl_rdata, rsp_ready,
    input  cmd_ready, tbl_we, tbl_waddr, tbl_wsel, tbl_wdata, tbl_re, tbl_raddr,
           tbl_rsel, rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_idx, cmd_sel, cmd_data, tbl_rdata, rsp_ready,
    output cmd_ready, tbl_we, tbl_waddr, tbl_wsel, tbl_wdata, tbl_re, tbl_raddr,
           tbl_rsel, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/lkt_table_writer.sv
// Host-command FSM that writes, clears and reads back entries of the lookup table,
// one outstanding command at a time.
module lkt_table_writer
  import lkt_pkg::*;
#(
  parameter int RESULT_WIDTH = lkt_config_pkg::RESULT_WIDTH_DEF,
  parameter int NUM_LOOKUPS  = lkt_config_pkg::NUM_LOOKUPS_DEF,
  parameter int NUM_CHOICES  = lkt_config_pkg::NUM_CHOICES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  lkt_table_writer_if.slave bus
);
  localparam int IDX_W = calc_idx_w(NUM_LOOKUPS);
  localparam int SEL_W = calc_sel_w(NUM_CHOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LOOKUPS - 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CHOICES - 1);

  typedef enum logic [2:0] {IDLE, WRITE, CLEAR, RD_REQ, RD_WAIT, RSP} state_e;

  state_e                  state, state_nxt;
  cmd_op_e                 op;
  logic                    accept, cmd_legal, clr_last;
  logic [IDX_W-1:0]        idx_q, clr_idx;
  logic [SEL_W-1:0]        sel_q, clr_sel;
  logic [RESULT_WIDTH-1:0] data_q, rsp_data_q;
  logic                    rsp_err_q;

  assign op       = cmd_op_e'(bus.cmd_op);
  assign accept   = (state == IDLE) && bus.cmd_valid;
  assign clr_last = (clr_idx == LAST_IDX) && (clr_sel == LAST_SEL);

  // CLEAR_ALL touches every entry, so its row/choice fields are don't-care.
  always_comb begin
    cmd_legal = 1'b0;
    case (op)
      OP_CLEAR_ALL:          cmd_legal = 1'b1;
      OP_WRITE, OP_READBACK: cmd_legal = (int'(bus.cmd_idx) < NUM_LOOKUPS) &&
                                         (int'(bus.cmd_sel) < NUM_CHOICES);
      default:               cmd_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.cmd_ready = 1'b0;
    bus.busy      = 1'b1;
    bus.tbl_we    = 1'b0;
    bus.tbl_waddr = '0;
    bus.tbl_wsel  = '0;
    bus.tbl_wdata = '0;
    bus.tbl_re    = 1'b0;
    bus.tbl_raddr = '0;
    bus.tbl_rsel  = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    bus.rsp_err   = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
        if (accept) begin
          if (!cmd_legal)                state_nxt = RSP;
          else if (op == OP_WRITE)       state_nxt = WRITE;
          else if (op == OP_CLEAR_ALL)   state_nxt = CLEAR;
          else                           state_nxt = RD_REQ;
        end
      end
      WRITE: begin
        bus.tbl_we    = 1'b1;
        bus.tbl_waddr = idx_q;
        bus.tbl_wsel  = sel_q;
        bus.tbl_wdata = data_q;
        state_nxt     = RSP;
      end
      CLEAR: begin
        bus.tbl_we    = 1'b1;
        bus.tbl_waddr = clr_idx;
        bus.tbl_wsel  = clr_sel;
        if (clr_last) state_nxt = RSP;
      end
      RD_REQ: begin
        bus.tbl_re    = 1'b1;
        bus.tbl_raddr = idx_q;
        bus.tbl_rsel  = sel_q;
        state_nxt     = RD_WAIT;
      end
      RD_WAIT: state_nxt = RSP;
      RSP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = rsp_data_q;
        bus.rsp_err   = rsp_err_q;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command capture, sweep counter and readback capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      sel_q      <= '0;
      data_q     <= '0;
      clr_idx    <= '0;
      clr_sel    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        idx_q      <= bus.cmd_idx;
        sel_q      <= bus.cmd_sel;
        data_q     <= bus.cmd_data;
        clr_idx    <= '0;
        clr_sel    <= '0;
        rsp_data_q <= '0;
        rsp_err_q  <= !cmd_legal;
      end
      // Sweep is row-major with the choice index fastest; it parks on the last entry.
      if (state == CLEAR && !clr_last) begin
        if (clr_sel == LAST_SEL) begin
          clr_sel <= '0;
          clr_idx <= clr_idx + 1'b1;
        end else begin
          clr_sel <= clr_sel + 1'b1;
        end
      end
      if (state == RD_WAIT) rsp_data_q <= bus.tbl_rdata;
    end
  end
endmodule

// File: tb/tb_lkt_table_writer.sv
// Directed bench for lkt_table_writer: default geometry DUT with a table model,
// plus a six-row instance for out-of-range index handling.
module tb_lkt_table_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  lkt_table_writer_if #(.RESULT_WIDTH(3), .NUM_LOOKUPS(8), .NUM_CHOICES(2)) bus ();
  lkt_table_writer_if #(.RESULT_WIDTH(3), .NUM_LOOKUPS(6), .NUM_CHOICES(2)) bus6 ();

  lkt_table_writer #(.RESULT_WIDTH(3), .NUM_LOOKUPS(8), .NUM_CHOICES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  lkt_table_writer #(.RESULT_WIDTH(3), .NUM_LOOKUPS(6), .NUM_CHOICES(2)) dut6 (
    .clk(clk), .rst_n(rst_n), .bus(bus6)
  );

  // Table model: synchronous write, registered read one cycle after tbl_re.
  logic [2:0] mem [8][2];
  logic [2:0] rdata_m = 3'd0;
  always @(posedge clk) begin
    if (bus.tbl_we) mem[bus.tbl_waddr][bus.tbl_wsel] <= bus.tbl_wdata;
    if (bus.tbl_re) rdata_m <= mem[bus.tbl_raddr][bus.tbl_rsel];
  end
  assign bus.tbl_rdata  = rdata_m;
  assign bus6.tbl_rdata = 3'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] idx, input logic sel, input logic [2:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_idx   = idx;
    bus.cmd_sel   = sel;
    bus.cmd_data  = data;
    chk("cmd_ready_at_accept", {31'd0, bus.cmd_ready}, 1);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic handshake(input string tag);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk({tag, "_idle_ready"}, {31'd0, bus.cmd_ready}, 1);
    chk({tag, "_idle_busy"}, {31'd0, bus.busy}, 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_idx = '0; bus.cmd_sel = '0;
    bus.cmd_data = '0;    bus.rsp_ready = 1'b0;
    bus6.cmd_valid = 1'b0; bus6.cmd_op = 2'd0; bus6.cmd_idx = '0; bus6.cmd_sel = '0;
    bus6.cmd_data = '0;    bus6.rsp_ready = 1'b0;

    // Reset state
    step(); step();
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 1);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_we_re", {30'd0, bus.tbl_we, bus.tbl_re}, 0);
    chk("rst_rsp", {27'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 0);
    rst_n = 1'b1;
    step();

    // WRITE idx5 sel1 data6
    send(2'd0, 3'd5, 1'b1, 3'd6);
    chk("wr_we", {31'd0, bus.tbl_we}, 1);
    chk("wr_addr_sel_data", {25'd0, bus.tbl_waddr, bus.tbl_wsel, bus.tbl_wdata}, {25'd0, 3'd5, 1'b1, 3'd6});
    chk("wr_re_rsp", {30'd0, bus.tbl_re, bus.rsp_valid}, 0);
    chk("wr_busy", {31'd0, bus.busy}, 1);
    step();
    chk("wr_we_off", {28'd0, bus.tbl_we, bus.tbl_waddr}, 0);
    chk("wr_rsp_valid", {31'd0, bus.rsp_valid}, 1);
    chk("wr_rsp_err_data", {28'd0, bus.rsp_err, bus.rsp_data}, 0);
    chk("wr_rsp_cmd_ready", {31'd0, bus.cmd_ready}, 0);
    handshake("wr");

    // WRITE idx2 sel0 data3, response stalled 10 cycles with a pending READBACK offered
    send(2'd0, 3'd2, 1'b0, 3'd3);
    chk("wr2_addr_sel_data", {25'd0, bus.tbl_waddr, bus.tbl_wsel, bus.tbl_wdata}, {25'd0, 3'd2, 1'b0, 3'd3});
    step();
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2; bus.cmd_idx = 3'd5; bus.cmd_sel = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("stall_rsp", {27'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_data}, {27'd0, 1'b1, 1'b0, 3'd0});
      chk("stall_ready_re", {30'd0, bus.cmd_ready, bus.tbl_re}, 0);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    // READBACK idx5 sel1 accepted now
    chk("rb_accept_ready", {31'd0, bus.cmd_ready}, 1);
    step();
    bus.cmd_valid = 1'b0;
    chk("rb_re", {31'd0, bus.tbl_re}, 1);
    chk("rb_raddr_rsel", {28'd0, bus.tbl_raddr, bus.tbl_rsel}, {28'd0, 3'd5, 1'b1});
    chk("rb_no_we", {31'd0, bus.tbl_we}, 0);
    step();
    chk("rb_wait", {30'd0, bus.tbl_re, bus.rsp_valid}, 0);
    step();
    chk("rb_rsp_valid", {31'd0, bus.rsp_valid}, 1);
    chk("rb_rsp_data", {29'd0, bus.rsp_data}, 6);
    chk("rb_rsp_err", {31'd0, bus.rsp_err}, 0);
    handshake("rb");

    send(2'd2, 3'd2, 1'b0, 3'd0);
    step(); step();
    chk("rb2_rsp_data", {28'd0, bus.rsp_valid, bus.rsp_data}, {28'd0, 1'b1, 3'd3});
    handshake("rb2");

    // CLEAR_ALL full sweep
    send(2'd1, 3'd7, 1'b1, 3'd5);
    for (int k = 0; k < 16; k++) begin
      chk("clr_we", {31'd0, bus.tbl_we}, 1);
      chk("clr_addr_sel", {28'd0, bus.tbl_waddr, bus.tbl_wsel}, k);
      chk("clr_data", {29'd0, bus.tbl_wdata}, 0);
      chk("clr_busy_rsp", {30'd0, bus.busy, bus.rsp_valid}, 2);
      step();
    end
    chk("clr_done_we", {31'd0, bus.tbl_we}, 0);
    chk("clr_rsp", {26'd0, bus.busy, bus.rsp_valid, bus.rsp_err, bus.rsp_data}, {26'd0, 2'b11, 4'd0});
    handshake("clr");

    send(2'd2, 3'd5, 1'b1, 3'd0);
    step(); step();
    chk("rb_after_clr", {28'd0, bus.rsp_valid, bus.rsp_data}, {28'd0, 1'b1, 3'd0});
    handshake("rb3");

    // Illegal opcode
    send(2'd3, 3'd1, 1'b0, 3'd1);
    chk("ill_op_rsp", {26'd0, bus.rsp_valid, bus.rsp_err, bus.tbl_we, bus.tbl_re, 2'd0}, {26'd0, 4'b1100, 2'd0});
    chk("ill_op_data", {29'd0, bus.rsp_data}, 0);
    handshake("ill");

    // Six-row instance: idx 7 and 6 rejected, idx 5 accepted
    for (int j = 0; j < 3; j++) begin
      bus6.cmd_valid = 1'b1; bus6.cmd_op = 2'd0; bus6.cmd_data = 3'd4; bus6.cmd_sel = 1'b0;
      bus6.cmd_idx = (j == 0) ? 3'd7 : (j == 1) ? 3'd6 : 3'd5;
      chk("six_ready", {31'd0, bus6.cmd_ready}, 1);
      step();
      bus6.cmd_valid = 1'b0;
      if (j < 2) begin
        chk("six_ill", {28'd0, bus6.rsp_valid, bus6.rsp_err, bus6.tbl_we, bus6.tbl_re}, {28'd0, 4'b1100});
      end else begin
        chk("six_legal_we", {28'd0, bus6.tbl_we, bus6.tbl_waddr}, {28'd0, 1'b1, 3'd5});
        step();
        chk("six_legal_rsp", {30'd0, bus6.rsp_valid, bus6.rsp_err}, 2);
      end
      bus6.rsp_ready = 1'b1;
      step();
      bus6.rsp_ready = 1'b0;
    end

    // Reset in clear cycle 7
    send(2'd1, 3'd0, 1'b0, 3'd0);
    for (int k = 0; k < 6; k++) step();
    chk("abort_pre_we", {27'd0, bus.tbl_we, bus.tbl_waddr, bus.tbl_wsel}, {27'd0, 1'b1, 3'd3, 1'b0});
    rst_n = 1'b0;
    #1;
    chk("abort_we", {31'd0, bus.tbl_we}, 0);
    chk("abort_ready_busy", {30'd0, bus.cmd_ready, bus.busy}, 2);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk("abort_no_rsp", {29'd0, bus.rsp_valid, bus.tbl_we, bus.busy}, 0);
      step();
    end
    send(2'd0, 3'd5, 1'b1, 3'd6);
    chk("post_wr_we", {25'd0, bus.tbl_we, bus.tbl_waddr, bus.tbl_wsel, bus.tbl_wdata}, {25'd0, 1'b1, 3'd5, 1'b1, 3'd6});
    step();
    chk("post_wr_rsp", {27'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_data}, {27'd0, 1'b1, 1'b0, 3'd0});
    handshake("post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
